// File: rtl/pid_mix.sv
// Heading-PID mixer: sums P/I/D terms, ramps forward speed, and emits
// saturated left/right motor commands two cycles after each err_vld.
module pid_mix #(
   parameter int unsigned FRWRD_INC = 4,
   parameter int unsigned FRWRD_DEC = 8,
   parameter int unsigned MAX_FRWRD = 672
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        moving,
   input  logic        err_vld,
   input  logic [13:0] P_term,
   input  logic [8:0]  I_term,
   input  logic [12:0] D_term,
   output logic [10:0] lft_spd,
   output logic [10:0] rght_spd,
   output logic        spd_vld,
   output logic        at_speed
);

   typedef enum logic [1:0] {IDLE, UP, CRUISE, DOWN} state_t;

   state_t             r_state, w_state_nxt;
   logic [9:0]         r_frwrd, w_frwrd_nxt;
   logic [10:0]        w_frwrd_inc;
   logic signed [14:0] w_sum, r_sum_q;
   logic               r_vld1;
   logic signed [11:0] w_pid;
   logic signed [13:0] w_frwrd_s, w_pid_s, w_lft_raw, w_rght_raw;
   logic [10:0]        r_lft, r_rght;
   logic               r_spd_vld;
   logic               w_at_speed;

   // Saturate a 14-bit signed value into 11-bit signed range.
   function automatic logic [10:0] sat11(input logic signed [13:0] v);
      if (v[13:10] == {4{v[13]}}) return v[10:0];
      else if (v[13])             return 11'h400;
      else                        return 11'h3FF;
   endfunction

   assign w_sum = {P_term[13], P_term}
                + {{6{I_term[8]}}, I_term}
                + {{2{D_term[12]}}, D_term};

   always_comb begin
      w_frwrd_inc = {1'b0, r_frwrd} + 11'(FRWRD_INC);
      if (moving)
         w_frwrd_nxt = (w_frwrd_inc > 11'(MAX_FRWRD)) ? 10'(MAX_FRWRD) : w_frwrd_inc[9:0];
      else
         w_frwrd_nxt = (r_frwrd < 10'(FRWRD_DEC)) ? '0 : r_frwrd - 10'(FRWRD_DEC);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM: next state, judged on the post-update forward speed
   always_comb begin
      w_state_nxt = r_state;
      if (err_vld) begin
         if (moving)
            w_state_nxt = (w_frwrd_nxt == 10'(MAX_FRWRD)) ? CRUISE : UP;
         else
            w_state_nxt = (w_frwrd_nxt == '0) ? IDLE : DOWN;
      end
   end

   // FSM: outputs
   always_comb begin
      w_at_speed = (r_state == CRUISE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frwrd <= '0;
         r_sum_q <= '0;
         r_vld1  <= 1'b0;
      end else begin
         r_vld1 <= err_vld;
         if (err_vld) begin
            r_frwrd <= w_frwrd_nxt;
            r_sum_q <= w_sum;
         end
      end
   end

   assign w_pid      = r_sum_q[14:3];
   assign w_frwrd_s  = {4'b0000, r_frwrd};
   assign w_pid_s    = {{2{w_pid[11]}}, w_pid};
   assign w_lft_raw  = w_frwrd_s + w_pid_s;
   assign w_rght_raw = w_frwrd_s - w_pid_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lft     <= '0;
         r_rght    <= '0;
         r_spd_vld <= 1'b0;
      end else begin
         r_spd_vld <= r_vld1;
         if (r_vld1) begin
            if (r_state == IDLE) begin
               r_lft  <= '0;
               r_rght <= '0;
            end else begin
               r_lft  <= sat11(w_lft_raw);
               r_rght <= sat11(w_rght_raw);
            end
         end
      end
   end

   assign lft_spd  = r_lft;
   assign rght_spd = r_rght;
   assign spd_vld  = r_spd_vld;
   assign at_speed = w_at_speed;

endmodule
